// File: rtl/candy_match_engine.sv
// rtl/candy_match_engine.sv - match/clear/gravity/refill engine for the candy board
//
// Purpose:
//   Scans the board for every horizontal and vertical run of >= MIN_RUN equal
//   colours, clears the marked cells, compacts each column downward and refills
//   the vacated top cells from RandColor. One pass per Start by default.
//   Optional feature macro: CANDY_CASCADE_EN -- repeat passes until a pass
//   clears nothing or MAX_PASSES passes have cleared cells.
//
// Ports:
//   Clk, Reset               clock; synchronous active-high reset
//   Enable                   0 freezes the FSM and all counters, WrEn forced low
//   Start                    one-cycle request, sampled only in IDLE
//   RdX, RdY / RdColor       board read address / combinational read data
//   WrEn, WrX, WrY, WrColor  board write port, at most one write per cycle
//   RandColor                refill colour, sampled in each FILL cycle
//   Busy                     high from the cycle after Start until Done
//   Done                     one-cycle pulse, board is final
//   Cleared                  cells cleared since last Start (saturating)
//   Passes                   passes that cleared at least one cell (saturating)

module candy_match_engine #(
   parameter int COLS       = 8,
   parameter int ROWS       = 8,
   parameter int CW         = 3,
   parameter int MIN_RUN    = 3,
   parameter int MAX_PASSES = 8,
   localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Enable,
   input  logic          Start,
   output logic [XW-1:0] RdX,
   output logic [YW-1:0] RdY,
   input  logic [CW-1:0] RdColor,
   output logic          WrEn,
   output logic [XW-1:0] WrX,
   output logic [YW-1:0] WrY,
   output logic [CW-1:0] WrColor,
   input  logic [CW-1:0] RandColor,
   output logic          Busy,
   output logic          Done,
   output logic [15:0]   Cleared,
   output logic [3:0]    Passes
);

   localparam int LMAX = (COLS > ROWS) ? COLS : ROWS;
   localparam int LW   = $clog2(LMAX + 1);
   localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
   localparam logic [3:0]    PASS_LIMIT = (MAX_PASSES > 15) ? 4'd15 : 4'(MAX_PASSES);

`ifdef CANDY_CASCADE_EN
   localparam bit CASCADE = 1'b1;
`else
   localparam bit CASCADE = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN_R,
      S_SCAN_C,
      S_CHECK,
      S_GRAV,
      S_FILL,
      S_DONE
   } state_t;

   state_t state, state_nx, col_next;

   logic [XW-1:0]                x;
   logic [YW-1:0]                y;
   logic [YW-1:0]                rp;
   logic [YW-1:0]                wp;
   logic [CW-1:0]                run_color;
   logic [LW-1:0]                run_len;
   logic [ROWS-1:0][COLS-1:0]    marks;

   int            scan_pos;
   int            scan_last;
   int            eval_end;
   logic          same;
   logic [LW-1:0] eval_len;
   logic          run_hit;
   logic          col_marked;
   logic          col_adv;
   logic          rescan;
   logic [15:0]   mark_cnt;
   logic [16:0]   cleared_sum;

   // Run tracking shared by both scan directions. A run is evaluated on the
   // cycle that ends it: a colour change closes the previous run (ending one
   // cell back), the last cell of the line closes the run including itself.
   always_comb begin
      scan_pos  = (state == S_SCAN_C) ? int'(y) : int'(x);
      scan_last = (state == S_SCAN_C) ? ROWS - 1 : COLS - 1;
      same      = (scan_pos != 0) && (RdColor == run_color);
      eval_len  = same ? run_len + LW'(1) : run_len;
      eval_end  = same ? scan_pos : scan_pos - 1;
      run_hit   = ((state == S_SCAN_R) || (state == S_SCAN_C)) &&
                  (scan_pos != 0) && (!same || (scan_pos == scan_last)) &&
                  (eval_len >= LW'(MIN_RUN));
   end

   always_comb begin
      col_marked = 1'b0;
      for (int r = 0; r < ROWS; r++) col_marked = col_marked | marks[r][x];
   end

   always_comb begin
      mark_cnt = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            mark_cnt = mark_cnt + 16'(marks[r][c]);
   end

   assign cleared_sum = {1'b0, Cleared} + {1'b0, mark_cnt};

   // Column finished: either an unmarked column (single GRAV cycle) or the
   // FILL cycle that wrote row 0.
   assign col_adv  = ((state == S_GRAV) && !col_marked) || ((state == S_FILL) && (wp == '0));
   assign rescan   = CASCADE && (Passes < PASS_LIMIT);
   assign col_next = (x != X_LAST) ? S_GRAV : (rescan ? S_SCAN_R : S_DONE);

   always_ff @(posedge Clk) begin
      if (Reset)       state <= S_IDLE;
      else if (Enable) state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      Busy     = 1'b0;
      Done     = 1'b0;
      WrEn     = 1'b0;
      RdX      = '0;
      RdY      = '0;
      WrX      = '0;
      WrY      = '0;
      WrColor  = '0;
      case (state)
         S_IDLE: begin
            if (Start) state_nx = S_SCAN_R;
         end
         S_SCAN_R: begin
            Busy = 1'b1;
            RdX  = x;
            RdY  = y;
            if ((x == X_LAST) && (y == Y_LAST)) state_nx = S_SCAN_C;
         end
         S_SCAN_C: begin
            Busy = 1'b1;
            RdX  = x;
            RdY  = y;
            if ((x == X_LAST) && (y == Y_LAST)) state_nx = S_CHECK;
         end
         S_CHECK: begin
            Busy     = 1'b1;
            state_nx = (marks == '0) ? S_DONE : S_GRAV;
         end
         S_GRAV: begin
            Busy = 1'b1;
            RdX  = x;
            RdY  = rp;
            if (!col_marked) begin
               state_nx = col_next;
            end else begin
               // wp never passes below rp, so the cell read here is still original
               if (!marks[rp][x]) begin
                  WrEn    = Enable;
                  WrX     = x;
                  WrY     = wp;
                  WrColor = RdColor;
               end
               if (rp == '0) state_nx = S_FILL;
            end
         end
         S_FILL: begin
            Busy    = 1'b1;
            WrEn    = Enable;
            WrX     = x;
            WrY     = wp;
            WrColor = RandColor;
            if (wp == '0) state_nx = col_next;
         end
         S_DONE: begin
            Done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x         <= '0;
         y         <= '0;
         rp        <= '0;
         wp        <= '0;
         run_color <= '0;
         run_len   <= '0;
         marks     <= '0;
         Cleared   <= '0;
         Passes    <= '0;
      end else if (Enable) begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  Cleared <= '0;
                  Passes  <= '0;
                  marks   <= '0;
                  x       <= '0;
                  y       <= '0;
               end
            end
            S_SCAN_R, S_SCAN_C: begin
               if (same) begin
                  run_len <= run_len + LW'(1);
               end else begin
                  run_color <= RdColor;
                  run_len   <= LW'(1);
               end
               if (run_hit) begin
                  if (state == S_SCAN_R) begin
                     for (int j = 0; j < COLS; j++)
                        if ((j <= eval_end) && (j > eval_end - int'(eval_len)))
                           marks[y][j] <= 1'b1;
                  end else begin
                     for (int j = 0; j < ROWS; j++)
                        if ((j <= eval_end) && (j > eval_end - int'(eval_len)))
                           marks[j][x] <= 1'b1;
                  end
               end
               if (state == S_SCAN_R) begin
                  if (x == X_LAST) begin
                     x <= '0;
                     y <= (y == Y_LAST) ? '0 : y + 1'b1;
                  end else begin
                     x <= x + 1'b1;
                  end
               end else begin
                  if (y == Y_LAST) begin
                     y <= '0;
                     x <= (x == X_LAST) ? '0 : x + 1'b1;
                  end else begin
                     y <= y + 1'b1;
                  end
               end
            end
            S_CHECK: begin
               if (marks != '0) begin
                  Cleared <= cleared_sum[16] ? 16'hFFFF : cleared_sum[15:0];
                  Passes  <= (Passes == 4'hF) ? Passes : Passes + 4'd1;
                  x       <= '0;
                  rp      <= Y_LAST;
                  wp      <= Y_LAST;
               end
            end
            S_GRAV: begin
               if (col_marked) begin
                  if (!marks[rp][x]) wp <= wp - 1'b1;
                  rp <= rp - 1'b1;
               end
            end
            S_FILL: begin
               if (wp != '0) wp <= wp - 1'b1;
            end
            default: ;
         endcase
         if (col_adv) begin
            if (x == X_LAST) begin
               marks <= '0;
               x     <= '0;
               y     <= '0;
            end else begin
               x  <= x + 1'b1;
               rp <= Y_LAST;
               wp <= Y_LAST;
            end
         end
      end
   end

endmodule
